hu_stall_ctrl: RTL and testbench

Hazard sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W). It decides every cycle which stage registers freeze and which are squashed to bubbles. It covers load-use RAW hazards, control redirects from E, multi-cycle MDU ops and data-memory wait states. It sits beside the E-stage forwarding mux and makes sure an operand the mux cannot supply is never consumed; it also keeps saturating performance counters.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/hu_sat_counter.sv | 25 ++
 rtl/hu_stall_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hu_stall_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the per-stage stall/flush bundle and the canned bundles for each priority level.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } hu_state_t;

   typedef struct packed {
      logic stall_F;
      logic stall_D;
      logic stall_E;
      logic stall_M;
      logic flush_D;
      logic flush_E;
      logic flush_M;
      logic flush_W;
   } stage_ctrl_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Bit order follows the struct: stall F/D/E/M then flush D/E/M/W.
   localparam stage_ctrl_t CTRL_NONE     = 8'b0000_0000;
   localparam stage_ctrl_t CTRL_MEM      = 8'b1111_0001;
   localparam stage_ctrl_t CTRL_MDU      = 8'b1110_0010;
   localparam stage_ctrl_t CTRL_REDIRECT = 8'b0000_1100;
   localparam stage_ctrl_t CTRL_RAW      = 8'b1100_0100;

endpackage

// File: rtl/hu_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module hu_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   // Count register: clears on reset, advances on inc until it reaches all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/hu_stall_ctrl.sv
// Hazard sequencing controller for a 5-stage RV32 pipeline: decides per cycle which
// stage registers freeze or get bubbles (load-use, redirect, MDU and data-memory waits).
module hu_stall_ctrl
   import pipeline_pkg::*;
#(
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             Rs1_used_D,
   input  logic             Rs2_used_D,
   input  logic [4:0]       Rd_E,
   input  logic             RegWrite_E,
   input  logic             MemRead_E,
   input  logic [4:0]       Rd_M,
   input  logic             RegWrite_M,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_W,
   input  logic             redirect_E,
   input  logic             mdu_start_E,
   input  logic             mdu_done,
   input  logic             dmem_req_M,
   input  logic             dmem_ready_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_M,
   output logic             flush_W,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   function automatic logic src_match(
      input logic [4:0] rs1,
      input logic       rs1_used,
      input logic [4:0] rs2,
      input logic       rs2_used,
      input logic [4:0] rd,
      input logic       wr
   );
      return wr && (rd != REG_X0) &&
             ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
   endfunction

   hu_state_t   state;
   hu_state_t   state_nxt;
   logic        pending;
   logic        pending_nxt;
   stage_ctrl_t ctrl;
   logic        redirect_win;

   logic match_e;
   logic match_m;
   logic match_w;
   logic lu;
   logic raw;
   logic memwait;
   logic mem_lvl;
   logic mdu_lvl;

   assign match_e = src_match(Rs1_D, Rs1_used_D, Rs2_D, Rs2_used_D, Rd_E, RegWrite_E);
   assign match_m = src_match(Rs1_D, Rs1_used_D, Rs2_D, Rs2_used_D, Rd_M, RegWrite_M);
   assign match_w = src_match(Rs1_D, Rs1_used_D, Rs2_D, Rs2_used_D, Rd_W, RegWrite_W);
   assign lu      = MemRead_E & match_e;
   assign memwait = dmem_req_M & ~dmem_ready_M;

   // Without forwarding every in-flight producer blocks D; with it only a load in E does.
   always_comb begin
      raw = 1'b0;
      if (FWD_EN != 0) begin
         raw = lu;
      end else begin
         raw = match_e | match_m | match_w;
      end
   end

   // A done pulse swallowed by a memory stall is remembered in pending and releases later.
   assign mem_lvl = memwait | ((state == MEM_WAIT) & ~dmem_ready_M);
   assign mdu_lvl = ((state == RUN) & mdu_start_E) |
                    ((state == MDU_WAIT) & ~mdu_done & ~pending);

   // Priority resolution of the stage control bundle; everything is quiet under reset.
   always_comb begin
      ctrl         = CTRL_NONE;
      redirect_win = 1'b0;
      if (rst) begin
         ctrl = CTRL_NONE;
      end else if (mem_lvl) begin
         ctrl = CTRL_MEM;
      end else if (mdu_lvl) begin
         ctrl = CTRL_MDU;
      end else if (redirect_E) begin
         ctrl         = CTRL_REDIRECT;
         redirect_win = 1'b1;
      end else if (raw) begin
         ctrl = CTRL_RAW;
      end else begin
         ctrl = CTRL_NONE;
      end
   end

   // Next-state and pending-done bookkeeping.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      case (state)
         RUN: begin
            pending_nxt = 1'b0;
            if (memwait) begin
               state_nxt = MEM_WAIT;
            end else if (mdu_start_E) begin
               state_nxt = MDU_WAIT;
            end else begin
               state_nxt = RUN;
            end
         end
         MDU_WAIT: begin
            if (mem_lvl) begin
               state_nxt   = MDU_WAIT;
               pending_nxt = pending | mdu_done;
            end else if (mdu_done || pending) begin
               state_nxt   = RUN;
               pending_nxt = 1'b0;
            end else begin
               state_nxt = MDU_WAIT;
            end
         end
         MEM_WAIT: begin
            pending_nxt = 1'b0;
            if (dmem_ready_M) begin
               state_nxt = RUN;
            end else begin
               state_nxt = MEM_WAIT;
            end
         end
         default: begin
            state_nxt   = RUN;
            pending_nxt = 1'b0;
         end
      endcase
   end

   // State and pending-flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

   assign stall_F = ctrl.stall_F;
   assign stall_D = ctrl.stall_D;
   assign stall_E = ctrl.stall_E;
   assign stall_M = ctrl.stall_M;
   assign flush_D = ctrl.flush_D;
   assign flush_E = ctrl.flush_E;
   assign flush_M = ctrl.flush_M;
   assign flush_W = ctrl.flush_W;
   assign busy    = ~rst & (state != RUN);

   hu_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ctrl.stall_F),
      .cnt (stall_cnt)
   );

   hu_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (redirect_win),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_hu_stall_ctrl.sv
// Directed bench for hu_stall_ctrl: a forwarding instance with 32-bit counters and a
// non-forwarding instance with 3-bit counters, both driven by the same stimulus.
module tb_hu_stall_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] Rs1_D, Rs2_D, Rd_E, Rd_M, Rd_W;
   logic       Rs1_used_D, Rs2_used_D, RegWrite_E, MemRead_E, RegWrite_M, RegWrite_W;
   logic       redirect_E, mdu_start_E, mdu_done, dmem_req_M, dmem_ready_M;

   logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W, busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic        stall_F0, stall_D0, stall_E0, stall_M0, flush_D0, flush_E0, flush_M0, flush_W0, busy0;
   logic [2:0]  stall_cnt0, flush_cnt0;

   logic [7:0] ctl, ctl0;
   assign ctl  = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};
   assign ctl0 = {stall_F0, stall_D0, stall_E0, stall_M0, flush_D0, flush_E0, flush_M0, flush_W0};

   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_MEM  = 8'b1111_0001;
   localparam logic [7:0] C_MDU  = 8'b1110_0010;
   localparam logic [7:0] C_RED  = 8'b0000_1100;
   localparam logic [7:0] C_RAW  = 8'b1100_0100;

   int checks = 0;
   int errors = 0;

   hu_stall_ctrl #(.FWD_EN(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_used_D(Rs1_used_D),
      .Rs2_used_D(Rs2_used_D), .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E),
      .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
      .redirect_E(redirect_E), .mdu_start_E(mdu_start_E), .mdu_done(mdu_done),
      .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
      .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hu_stall_ctrl #(.FWD_EN(0), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_used_D(Rs1_used_D),
      .Rs2_used_D(Rs2_used_D), .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E),
      .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
      .redirect_E(redirect_E), .mdu_start_E(mdu_start_E), .mdu_done(mdu_done),
      .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
      .stall_F(stall_F0), .stall_D(stall_D0), .stall_E(stall_E0), .stall_M(stall_M0),
      .flush_D(flush_D0), .flush_E(flush_E0), .flush_M(flush_M0), .flush_W(flush_W0),
      .busy(busy0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clear_inputs();
      Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_used_D = 1'b0; Rs2_used_D = 1'b0;
      Rd_E = 5'd0; RegWrite_E = 1'b0; MemRead_E = 1'b0;
      Rd_M = 5'd0; RegWrite_M = 1'b0; Rd_W = 5'd0; RegWrite_W = 1'b0;
      redirect_E = 1'b0; mdu_start_E = 1'b0; mdu_done = 1'b0;
      dmem_req_M = 1'b0; dmem_ready_M = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rst_ctl: got %b expected %b", ctl, C_NONE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      dmem_req_M = 1'b1; mdu_start_E = 1'b1; redirect_E = 1'b1;
      MemRead_E = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd5; Rs1_used_D = 1'b1; Rs1_D = 5'd5;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rst_forced_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d expected 0", flush_cnt); end
      clear_inputs();
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_load_use();
      next_cycle();
      MemRead_E = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd5;
      Rs1_used_D = 1'b1; Rs1_D = 5'd5; Rs2_used_D = 1'b1; Rs2_D = 5'd9;
      #1;
      checks++; if (ctl !== C_RAW) begin errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, C_RAW); end
      next_cycle();
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
      MemRead_E = 1'b0; RegWrite_E = 1'b0; Rd_E = 5'd0; RegWrite_M = 1'b1; Rd_M = 5'd5;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_next_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      clear_inputs();
      MemRead_E = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd0; Rs1_used_D = 1'b1; Rs1_D = 5'd0;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_x0_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      clear_inputs();
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_x0_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_redirect_vs_raw();
      next_cycle();
      MemRead_E = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd6; Rs2_used_D = 1'b1; Rs2_D = 5'd6;
      redirect_E = 1'b1;
      #1;
      checks++; if (ctl !== C_RED) begin errors++; $display("FAIL red_ctl: got %b expected %b", ctl, C_RED); end
      next_cycle();
      clear_inputs();
      checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL red_flush_cnt: got %0d expected 1", flush_cnt); end
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL red_stall_cnt: got %0d expected 1", stall_cnt); end
   endtask

   task automatic test_mdu();
      next_cycle();
      mdu_start_E = 1'b1;
      #1;
      checks++; if (ctl !== C_MDU) begin errors++; $display("FAIL mdu_start_ctl: got %b expected %b", ctl, C_MDU); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mdu_start_busy: got %b expected 0", busy); end
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         mdu_start_E = 1'b0;
         #1;
         checks++; if (ctl !== C_MDU) begin errors++; $display("FAIL mdu_wait_ctl[%0d]: got %b expected %b", i, ctl, C_MDU); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mdu_wait_busy[%0d]: got %b expected 1", i, busy); end
      end
      next_cycle();
      mdu_done = 1'b1;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mdu_done_ctl: got %b expected %b", ctl, C_NONE); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mdu_done_busy: got %b expected 1", busy); end
      next_cycle();
      mdu_done = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mdu_end_busy: got %b expected 0", busy); end
      checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL mdu_stall_cnt: got %0d expected 5", stall_cnt); end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         dmem_req_M = 1'b1; dmem_ready_M = 1'b0;
         #1;
         checks++; if (ctl !== C_MEM) begin errors++; $display("FAIL mem_ctl[%0d]: got %b expected %b", i, ctl, C_MEM); end
         checks++; if (busy !== (i != 0)) begin errors++; $display("FAIL mem_busy[%0d]: got %b expected %b", i, busy, (i != 0)); end
      end
      next_cycle();
      dmem_ready_M = 1'b1;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mem_ready_ctl: got %b expected %b", ctl, C_NONE); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mem_ready_busy: got %b expected 1", busy); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mem_end_busy: got %b expected 0", busy); end
      checks++; if (stall_cnt !== 32'd8) begin errors++; $display("FAIL mem_stall_cnt: got %0d expected 8", stall_cnt); end
   endtask

   task automatic test_overlap();
      next_cycle();
      mdu_start_E = 1'b1;
      #1;
      checks++; if (ctl !== C_MDU) begin errors++; $display("FAIL ovl_start_ctl: got %b expected %b", ctl, C_MDU); end
      next_cycle();
      mdu_start_E = 1'b0; dmem_req_M = 1'b1; dmem_ready_M = 1'b0; mdu_done = 1'b1;
      #1;
      checks++; if (ctl !== C_MEM) begin errors++; $display("FAIL ovl_mem1_ctl: got %b expected %b", ctl, C_MEM); end
      next_cycle();
      mdu_done = 1'b0; redirect_E = 1'b1;
      #1;
      checks++; if (ctl !== C_MEM) begin errors++; $display("FAIL ovl_mem2_ctl: got %b expected %b", ctl, C_MEM); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_mem2_busy: got %b expected 1", busy); end
      next_cycle();
      dmem_req_M = 1'b0;
      #1;
      checks++; if (ctl !== C_RED) begin errors++; $display("FAIL ovl_release_ctl: got %b expected %b", ctl, C_RED); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_release_busy: got %b expected 1", busy); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_end_busy: got %b expected 0", busy); end
      checks++; if (stall_cnt !== 32'd11) begin errors++; $display("FAIL ovl_stall_cnt: got %0d expected 11", stall_cnt); end
      checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL ovl_flush_cnt: got %0d expected 2", flush_cnt); end
   endtask

   task automatic test_fwd0();
      next_cycle();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      RegWrite_W = 1'b1; Rd_W = 5'd7; Rs2_used_D = 1'b1; Rs2_D = 5'd7;
      #1;
      checks++; if (ctl0 !== C_RAW) begin errors++; $display("FAIL f0_w_ctl: got %b expected %b", ctl0, C_RAW); end
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL f1_w_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      checks++; if (ctl0 !== C_RAW) begin errors++; $display("FAIL f0_w_hold_ctl: got %b expected %b", ctl0, C_RAW); end
      next_cycle();
      RegWrite_W = 1'b0;
      #1;
      checks++; if (ctl0 !== C_NONE) begin errors++; $display("FAIL f0_w_clear_ctl: got %b expected %b", ctl0, C_NONE); end
      next_cycle();
      clear_inputs();
      RegWrite_M = 1'b1; Rd_M = 5'd3; Rs1_used_D = 1'b1; Rs1_D = 5'd3;
      #1;
      checks++; if (ctl0 !== C_RAW) begin errors++; $display("FAIL f0_m_ctl: got %b expected %b", ctl0, C_RAW); end
      next_cycle();
      clear_inputs();
      RegWrite_E = 1'b1; Rd_E = 5'd4; Rs1_used_D = 1'b1; Rs1_D = 5'd4;
      #1;
      checks++; if (ctl0 !== C_RAW) begin errors++; $display("FAIL f0_e_ctl: got %b expected %b", ctl0, C_RAW); end
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL f1_e_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      clear_inputs();
      RegWrite_M = 1'b1; Rd_M = 5'd0; Rs1_used_D = 1'b1; Rs1_D = 5'd0;
      #1;
      checks++; if (ctl0 !== C_NONE) begin errors++; $display("FAIL f0_x0_ctl: got %b expected %b", ctl0, C_NONE); end
      next_cycle();
      clear_inputs();
      checks++; if (stall_cnt0 !== 3'd4) begin errors++; $display("FAIL f0_stall_cnt: got %0d expected 4", stall_cnt0); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         dmem_req_M = 1'b1; dmem_ready_M = 1'b0;
      end
      next_cycle();
      dmem_ready_M = 1'b1;
      #1;
      checks++; if (stall_cnt0 !== 3'd7) begin errors++; $display("FAIL sat_stall_cnt: got %0d expected 7", stall_cnt0); end
      next_cycle();
      clear_inputs();
      checks++; if (stall_cnt0 !== 3'd7) begin errors++; $display("FAIL sat_hold_cnt: got %0d expected 7", stall_cnt0); end
   endtask

   task automatic test_async_reset();
      next_cycle();
      mdu_start_E = 1'b1;
      next_cycle();
      mdu_start_E = 1'b0; dmem_req_M = 1'b1; dmem_ready_M = 1'b0; mdu_done = 1'b1;
      next_cycle();
      mdu_done = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL arst_ctl: got %b expected %b", ctl, C_NONE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_stall_cnt: got %0d expected 0", stall_cnt); end
      checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL arst_flush_cnt: got %0d expected 0", flush_cnt); end
      clear_inputs();
      next_cycle();
      rst = 1'b0;
      mdu_start_E = 1'b1;
      #1;
      checks++; if (ctl !== C_MDU) begin errors++; $display("FAIL arst_restart_ctl: got %b expected %b", ctl, C_MDU); end
      next_cycle();
      mdu_start_E = 1'b0;
      #1;
      checks++; if (ctl !== C_MDU) begin errors++; $display("FAIL arst_pending_clr_ctl: got %b expected %b", ctl, C_MDU); end
      next_cycle();
      mdu_done = 1'b1;
      #1;
      checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL arst_done_ctl: got %b expected %b", ctl, C_NONE); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_end_busy: got %b expected 0", busy); end
      checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL arst_stall_cnt2: got %0d expected 2", stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect_vs_raw();
      test_mdu();
      test_mem_wait();
      test_overlap();
      test_fwd0();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
